// File: rtl/dzcpu_uop_sequencer.sv
// Microcode sequencer: accepts an opcode, walks its uop flow in the ROM, decodes the control field
// into one-cycle strobes and aborts runaway flows with a sticky watchdog error.
module dzcpu_uop_sequencer #(
   parameter int unsigned WATCHDOG_MAX = 32
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iOpcodeValid,
   input  logic [7:0]  iOpcode,
   output logic        oOpcodeReady,
   output logic [7:0]  oMop,
   input  logic [7:0]  iFlowIdx,
   input  logic [7:0]  iCbFlowIdx,
   output logic [7:0]  oUopAddr,
   input  logic [12:0] iUop,
   input  logic        iStall,
   input  logic        iFlagZ,
   output logic        oUopValid,
   output logic        oPcInc,
   output logic        oFlagUpdate,
   output logic        oEof,
   output logic        oError
);

   localparam int unsigned CW = $clog2(WATCHDOG_MAX + 1);

   typedef enum logic [1:0] {IDLE, DISPATCH, EXEC, CBWAIT} state_t;

   state_t          r_state;
   logic [7:0]      r_mop;
   logic [7:0]      r_addr;
   logic [CW-1:0]   r_cnt;
   logic            r_error;

   logic [3:0]      w_ctrl;
   logic            w_issue;
   logic            w_pc;
   logic            w_fu;
   logic            w_term;
   logic            w_jcb;
   logic            w_wd_trip;
   logic            w_unused_uop;

   assign w_ctrl       = iUop[12:9];
   assign w_unused_uop = ^iUop[8:0];
   assign w_issue      = (r_state == EXEC) && !iStall;

   always_comb begin
      w_pc   = 1'b0;
      w_fu   = 1'b0;
      w_term = 1'b0;
      w_jcb  = 1'b0;
      case (w_ctrl)
         4'd1: w_pc = 1'b1;
         4'd2: w_term = 1'b1;
         4'd3: begin w_pc = 1'b1; w_term = 1'b1; end
         4'd4: begin w_fu = 1'b1; w_term = 1'b1; end
         4'd5: begin w_pc = 1'b1; w_fu = 1'b1; w_term = 1'b1; end
         4'd6: begin w_pc = 1'b1; w_term = iFlagZ; end
         4'd7: begin w_pc = 1'b1; w_term = !iFlagZ; end
         4'd8: w_fu = 1'b1;
         4'd9: begin w_pc = 1'b1; w_jcb = 1'b1; end
         default: ;
      endcase
   end

   // The last uop the watchdog allows must itself end the flow, otherwise the flow is aborted.
   assign w_wd_trip = w_issue && !w_term && (r_cnt == CW'(WATCHDOG_MAX - 1));

   assign oOpcodeReady = (r_state == IDLE);
   assign oMop         = r_mop;
   assign oUopAddr     = r_addr;
   assign oUopValid    = w_issue;
   assign oPcInc       = w_issue && w_pc;
   assign oFlagUpdate  = w_issue && w_fu;
   assign oEof         = w_issue && (w_term || w_wd_trip);
   assign oError       = r_error || w_wd_trip;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         r_state <= IDLE;
         r_mop   <= 8'd0;
         r_addr  <= 8'd0;
         r_cnt   <= '0;
         r_error <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Acceptance deliberately ignores iStall.
               if (iOpcodeValid) begin
                  r_mop   <= iOpcode;
                  r_state <= DISPATCH;
               end
            end
            DISPATCH: begin
               if (!iStall) begin
                  r_addr  <= iFlowIdx;
                  r_cnt   <= '0;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (!iStall) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (w_term || w_wd_trip) begin
                     r_state <= IDLE;
                     if (w_wd_trip) r_error <= 1'b1;
                  end else if (w_jcb) begin
                     r_state <= CBWAIT;
                  end else begin
                     r_addr <= r_addr + 8'd1;
                  end
               end
            end
            CBWAIT: begin
               if (!iStall) begin
                  r_addr  <= iCbFlowIdx;
                  r_state <= EXEC;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Bench for dzcpu_uop_sequencer: directed flows with literal expectations plus randomized
// traffic, all compared every cycle against a flow-level model of the sequencer.
module tb_dzcpu_uop_sequencer;

   localparam int WD = 32;

   logic        iClock = 1'b0;
   logic        iReset = 1'b1;
   logic        iOpcodeValid = 1'b0;
   logic [7:0]  iOpcode = 8'd0;
   logic        oOpcodeReady;
   logic [7:0]  oMop;
   logic [7:0]  iFlowIdx;
   logic [7:0]  iCbFlowIdx;
   logic [7:0]  oUopAddr;
   logic [12:0] iUop;
   logic        iStall = 1'b0;
   logic        iFlagZ = 1'b0;
   logic        oUopValid;
   logic        oPcInc;
   logic        oFlagUpdate;
   logic        oEof;
   logic        oError;

   logic [12:0] rom [256];
   logic [7:0]  flow_lut [256];
   logic [7:0]  cb_lut [256];

   int checks = 0;
   int failures = 0;

   dzcpu_uop_sequencer #(.WATCHDOG_MAX(WD)) dut (
      .iClock       (iClock),
      .iReset       (iReset),
      .iOpcodeValid (iOpcodeValid),
      .iOpcode      (iOpcode),
      .oOpcodeReady (oOpcodeReady),
      .oMop         (oMop),
      .iFlowIdx     (iFlowIdx),
      .iCbFlowIdx   (iCbFlowIdx),
      .oUopAddr     (oUopAddr),
      .iUop         (iUop),
      .iStall       (iStall),
      .iFlagZ       (iFlagZ),
      .oUopValid    (oUopValid),
      .oPcInc       (oPcInc),
      .oFlagUpdate  (oFlagUpdate),
      .oEof         (oEof),
      .oError       (oError)
   );

   assign iUop       = rom[oUopAddr];
   assign iFlowIdx   = flow_lut[oMop];
   assign iCbFlowIdx = cb_lut[oMop];

   initial forever #5 iClock = ~iClock;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- flow-level reference model ----------------
   // A flow is: accept, one dead cycle, then uops; jcb costs one dead cycle and reloads the address.
   logic [15:0] pc_mask  = 16'h02EA;  // codes 1,3,5,6,7,9
   logic [15:0] fu_mask  = 16'h0130;  // codes 4,5,8
   logic [15:0] eof_mask = 16'h003C;  // codes 2..5

   bit       m_active = 0, n_active;
   int       m_wait = 0, n_wait;
   bit       m_cb = 0, n_cb;
   logic [7:0] m_addr = 0, n_addr;
   logic [7:0] m_mop = 0, n_mop;
   int       m_cnt = 0, n_cnt;
   bit       m_err = 0, n_err;

   always @(negedge iClock) begin
      logic [3:0] c;
      bit iss, term, wd;
      if (!iReset) begin
         chk("rst_addr", oUopAddr, 0);
         chk("rst_valid", oUopValid, 0);
         chk("rst_eof", oEof, 0);
         chk("rst_err", oError, 0);
         n_active = 0; n_wait = 0; n_cb = 0; n_addr = 0; n_mop = 0; n_cnt = 0; n_err = 0;
      end else begin
         iss  = m_active && (m_wait == 0) && !iStall;
         c    = rom[m_addr][12:9];
         term = eof_mask[c] || (c == 4'd6 && iFlagZ) || (c == 4'd7 && !iFlagZ);
         wd   = iss && !term && (m_cnt == WD - 1);
         chk("ready", oOpcodeReady, !m_active);
         chk("valid", oUopValid, iss);
         chk("addr", oUopAddr, m_addr);
         chk("mop", oMop, m_mop);
         chk("pcinc", oPcInc, iss && pc_mask[c]);
         chk("flagupd", oFlagUpdate, iss && fu_mask[c]);
         chk("eof", oEof, iss && (term || wd));
         chk("error", oError, m_err || wd);
         n_active = m_active; n_wait = m_wait; n_cb = m_cb; n_addr = m_addr;
         n_mop = m_mop; n_cnt = m_cnt; n_err = m_err;
         if (!m_active) begin
            if (iOpcodeValid) begin
               n_active = 1; n_wait = 1; n_cb = 0; n_mop = iOpcode;
            end
         end else if (!iStall) begin
            if (m_wait > 0) begin
               n_wait = 0;
               n_addr = m_cb ? cb_lut[m_mop] : flow_lut[m_mop];
               if (!m_cb) n_cnt = 0;
            end else begin
               n_cnt = m_cnt + 1;
               if (term || wd) begin
                  n_active = 0;
                  if (wd) n_err = 1;
               end else if (c == 4'd9) begin
                  n_wait = 1; n_cb = 1;
               end else begin
                  n_addr = m_addr + 8'd1;
               end
            end
         end
      end
   end

   always @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         m_active = 0; m_wait = 0; m_cb = 0; m_addr = 0; m_mop = 0; m_cnt = 0; m_err = 0;
      end else begin
         m_active = n_active; m_wait = n_wait; m_cb = n_cb; m_addr = n_addr;
         m_mop = n_mop; m_cnt = n_cnt; m_err = n_err;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge iClock);
      #3;
   endtask

   task automatic setc(input int a, input int c);
      logic [3:0] cc;
      cc = c[3:0];
      rom[a[7:0]] = {cc, 9'($urandom)};
   endtask

   task automatic accept(input logic [7:0] op);
      int n = 0;
      while (!oOpcodeReady && n < 100) begin
         tick();
         n++;
      end
      if (!oOpcodeReady) chk("accept_timeout", 0, 1);
      iOpcode = op;
      iOpcodeValid = 1'b1;
      tick();
      iOpcodeValid = 1'b0;
   endtask

   task automatic load_basic();
      setc(5, 1); setc(6, 1); setc(7, 0); setc(8, 3);
      setc(19, 6); setc(20, 2);
      setc(13, 0); setc(14, 0); setc(15, 9); setc(16, 4);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[i] = 13'h0400;  // eof
         flow_lut[i] = 8'($urandom);
         cb_lut[i] = 8'($urandom);
      end
      flow_lut[8'h21] = 8'd5;
      flow_lut[8'h34] = 8'd19;
      flow_lut[8'h35] = 8'd13;
      cb_lut[8'h35]   = 8'd16;
      flow_lut[8'h37] = 8'd250;
      load_basic();

      #1 iReset = 1'b0;
      #1;
      chk("lit_rst_addr", oUopAddr, 0);
      chk("lit_rst_mop", oMop, 0);
      chk("lit_rst_err", oError, 0);
      tick(); tick();
      iReset = 1'b1;
      #1 chk("lit_rst_ready", oOpcodeReady, 1);

      // Basic flow 5..8: inc,inc,op,inc_eof
      accept(8'h21);
      tick(); chk("f1_a5", oUopAddr, 5); chk("f1_pc5", oPcInc, 1); chk("f1_v5", oUopValid, 1);
      tick(); chk("f1_a6", oUopAddr, 6); chk("f1_pc6", oPcInc, 1);
      tick(); chk("f1_a7", oUopAddr, 7); chk("f1_pc7", oPcInc, 0);
      tick(); chk("f1_a8", oUopAddr, 8); chk("f1_pc8", oPcInc, 1); chk("f1_eof", oEof, 1);
      chk("f1_rdy_eof", oOpcodeReady, 0);
      tick(); chk("f1_rdy_after", oOpcodeReady, 1);

      // Conditional eof on Z
      iFlagZ = 1'b1;
      accept(8'h34);
      tick(); chk("z1_a", oUopAddr, 19); chk("z1_eof", oEof, 1); chk("z1_pc", oPcInc, 1);
      tick(); chk("z1_rdy", oOpcodeReady, 1);
      iFlagZ = 1'b0;
      accept(8'h34);
      tick(); chk("z0_a", oUopAddr, 19); chk("z0_eof", oEof, 0); chk("z0_pc", oPcInc, 1);
      tick(); chk("z0_a20", oUopAddr, 20); chk("z0_v20", oUopValid, 1);
      tick();

      // CB prefix jump
      accept(8'h35);
      tick(); chk("cb_a13", oUopAddr, 13);
      tick(); chk("cb_a14", oUopAddr, 14);
      tick(); chk("cb_a15", oUopAddr, 15); chk("cb_pc15", oPcInc, 1);
      tick(); chk("cb_gap", oUopValid, 0);
      tick(); chk("cb_a16", oUopAddr, 16); chk("cb_fu", oFlagUpdate, 1); chk("cb_eof", oEof, 1);
      tick();

      // Stall for 3 cycles at addr 6
      accept(8'h21);
      tick(); tick();
      iStall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("st_addr", oUopAddr, 6); chk("st_valid", oUopValid, 0); chk("st_pc", oPcInc, 0);
         if (k < 2) tick();
      end
      tick();
      iStall = 1'b0;
      #1 chk("st_res6", oUopAddr, 6); chk("st_res_v", oUopValid, 1); chk("st_res_pc", oPcInc, 1);
      tick(); chk("st_res7", oUopAddr, 7);
      tick(); tick();

      // Watchdog across the 255->0 wrap
      for (int a = 250; a < 256; a++) setc(a, 0);
      for (int a = 0; a < 32; a++) setc(a, 0);
      accept(8'h37);
      tick(); chk("wd_a250", oUopAddr, 250);
      for (int k = 2; k <= 32; k++) begin
         tick();
         if (k == 7) chk("wd_wrap", oUopAddr, 0);
         if (k == 31) chk("wd_no_err31", oError, 0);
      end
      chk("wd_a25", oUopAddr, 25); chk("wd_err", oError, 1); chk("wd_eof", oEof, 1);
      tick(); chk("wd_rdy", oOpcodeReady, 1); chk("wd_sticky", oError, 1);
      load_basic();

      // Asynchronous reset mid-flow
      accept(8'h21);
      tick(); tick(); tick();
      chk("rs_a7", oUopAddr, 7);
      iReset = 1'b0;
      #1;
      chk("rs_addr", oUopAddr, 0); chk("rs_mop", oMop, 0); chk("rs_valid", oUopValid, 0);
      chk("rs_eof", oEof, 0); chk("rs_err", oError, 0); chk("rs_pc", oPcInc, 0);
      tick();
      iReset = 1'b1;
      #1 chk("rs_rdy", oOpcodeReady, 1);
      accept(8'h21);
      tick(); chk("rs_new_a5", oUopAddr, 5); chk("rs_new_pc", oPcInc, 1);
      tick(); tick(); tick(); tick();

      // Randomized traffic; low opcodes run long op-only flows to reach the watchdog
      for (int i = 0; i < 256; i++) begin
         logic [3:0] c;
         c = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         rom[i] = {c, 9'($urandom)};
      end
      for (int a = 100; a < 150; a++) setc(a, 0);
      for (int i = 0; i < 16; i++) flow_lut[i] = 8'd100;
      for (int i = 0; i < 3000; i++) begin
         iOpcodeValid = ($urandom_range(0, 3) != 0);
         iOpcode      = 8'($urandom);
         iStall       = ($urandom_range(0, 4) == 0);
         iFlagZ       = 1'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            iReset = 1'b0;
            tick();
            iReset = 1'b1;
         end
         tick();
      end
      iOpcodeValid = 1'b0;
      iStall = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dzcpu_uop_sequencer.md
DZCPU_UOP_SEQUENCER -- requirements
Module: dzcpu_uop_sequencer

Interface
REQ-001 Parameter WATCHDOG_MAX, default 32, SHALL set the maximum uops issued per flow before abort.
REQ-002 iClock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 iReset  input  1  reset; asynchronous, active-low.
REQ-004 iOpcodeValid  input  1  fetch unit presents an opcode.
REQ-005 iOpcode  input  8  opcode byte.
REQ-006 oOpcodeReady  output  1  sequencer can accept an opcode this cycle.
REQ-007 oMop  output  8  registered opcode driven to the opcode flow LUT.
REQ-008 iFlowIdx  input  8  flow start index returned combinationally by the opcode LUT.
REQ-009 iCbFlowIdx  input  8  flow start index returned combinationally by the CB-prefix LUT.
REQ-010 oUopAddr  output  8  microcode ROM address.
REQ-011 iUop  input  13  ROM word for oUopAddr, same cycle; control field = iUop[12:9].
REQ-012 iStall  input  1  memory or datapath busy; freezes sequencing.
REQ-013 iFlagZ  input  1  current Z flag.
REQ-014 oUopValid  output  1  iUop is being issued to the datapath this cycle.
REQ-015 oPcInc  output  1  one-cycle PC increment strobe.
REQ-016 oFlagUpdate  output  1  one-cycle flag-update strobe.
REQ-017 oEof  output  1  one-cycle end-of-flow strobe.
REQ-018 oError  output  1  sticky watchdog error flag.

Function
REQ-019 States SHALL be IDLE, DISPATCH, EXEC and CBWAIT.
REQ-020 IDLE: oOpcodeReady=1; on iOpcodeValid, latch iOpcode into oMop and go to DISPATCH.
REQ-021 DISPATCH: load the address register from iFlowIdx, clear the uop counter, and go to EXEC; first uop issues 2 cycles after acceptance.
REQ-022 EXEC: oUopValid=1 while iStall=0; oUopAddr equals the address register.
REQ-023 Strobes SHALL be combinational from iUop[12:9], qualified by EXEC and !iStall.
REQ-024 Control codes SHALL be decoded as follows:
- 0 op: addr+1.
- 1 inc: oPcInc; addr+1.
- 2 eof: oEof; go to IDLE.
- 3 inc_eof: oPcInc and oEof; go to IDLE.
- 4 eof_fu: oFlagUpdate and oEof; go to IDLE.
- 5 inc_eof_fu: oPcInc, oFlagUpdate and oEof; go to IDLE.
- 6 inc_eof_z: oPcInc; if iFlagZ=1, oEof and go to IDLE, else addr+1.
- 7 inc_eof_nz: oPcInc; if iFlagZ=0, oEof and go to IDLE, else addr+1.
- 8 update_flags: oFlagUpdate; addr+1.
- 9 jcb: oPcInc; go to CBWAIT.
- 10-15: treat as op.
REQ-025 CBWAIT SHALL last exactly one cycle with oUopValid=0; it loads the address from iCbFlowIdx and returns to EXEC, and the uop counter keeps counting.
REQ-026 iStall=1 SHALL hold state, address, counter and oMop, and force all strobes and oUopValid to 0; this applies in every state except IDLE acceptance, which ignores iStall.
REQ-027 Address arithmetic SHALL be 8-bit modulo, so 255+1 wraps to 0.
REQ-028 The uop counter SHALL increment on every issued uop. If a uop is issued with count = WATCHDOG_MAX-1 and is not eof-terminating, the sequencer SHALL:
- set oError;
- pulse oEof;
- go to IDLE.
REQ-029 oError SHALL clear only on reset.
REQ-030 oOpcodeReady SHALL be 0 in the eof cycle and 1 in the following cycle, giving back-to-back flows a 1-cycle gap.

Reset
REQ-031 While iReset=0, the block SHALL be in IDLE with:
- oMop, oUopAddr and the uop counter = 0;
- oUopValid, oPcInc, oFlagUpdate, oEof and oError = 0;
- oOpcodeReady = 1 once iReset is released.
REQ-032 A reset asserted mid-flow SHALL abort the flow immediately, with no oEof pulse.

Verification
REQ-033 Opcode 0x21, iFlowIdx=5, ROM ctrl 5..8 = inc,inc,op,inc_eof -> accept at T; oUopAddr 5,6,7,8 at T+2..T+5; oPcInc at T+2, T+3 and T+5; oEof at T+5; oOpcodeReady=1 at T+6.
REQ-034 Flow at 19 with ctrl=6: iFlagZ=1 -> oEof at addr 19; iFlagZ=0 -> addr 20 is issued next with oEof=0.
REQ-035 Flow at 13: op, op, jcb; iCbFlowIdx=16, ROM16=eof_fu -> addr 13,14,15, one idle cycle, then addr 16 with oFlagUpdate=1 and oEof=1.
REQ-036 iStall held for 3 cycles at addr 6 -> oUopAddr stays 6 with no strobes, then resumes at 6 and 7.
REQ-037 Flow at 250 with all ctrl=op -> addresses wrap 255 to 0, and the 32nd uop asserts oError=1 and oEof=1.
REQ-038 iReset pulled low during addr 7 -> outputs reach reset values without a clock edge, and the next flow starts cleanly.
